// File: rtl/alu_issue_if.sv
// Issue-stage bus: upstream instruction/operand handshake plus downstream decoded ALU op.
// master = producer/consumer environment, slave = the alu_issue block.
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [63:0] pc;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  alu_function;
    logic [63:0] operand_a;
    logic [63:0] operand_b;
    logic        is_word;
    logic        is_branch;
    logic        branch_invert;
    logic        illegal;

    modport master (
        output in_valid, instruction, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, alu_function, operand_a, operand_b,
               is_word, is_branch, branch_invert, illegal
    );

    modport slave (
        input  in_valid, instruction, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, alu_function, operand_a, operand_b,
               is_word, is_branch, branch_invert, illegal
    );
endinterface

// File: rtl/alu_issue.sv
// RV64I integer-ALU issue stage: decodes one instruction into ALU function/operands, registered.
// Define ALU_ISSUE_SKID_EN for a 2-entry skid buffer with a flopped in_ready.
module alu_issue (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    alu_issue_if.slave bus
);
    typedef struct packed {
        logic [4:0]  alu_function;
        logic [63:0] operand_a;
        logic [63:0] operand_b;
        logic        is_word;
        logic        is_branch;
        logic        branch_invert;
        logic        illegal;
    } dec_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP32   = 7'b0111011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_IMM32  = 7'b0011011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [31:0] inst;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        alt;
    logic        w_f3_ok;
    logic        shift;
    logic [63:0] imm_i, imm_s, imm_u;
    logic [63:0] rs1_w_z, rs1_w_s;
    logic        word;
    logic        bad;
    dec_t        dec;

    assign inst    = bus.instruction;
    assign f3      = inst[14:12];
    assign f7      = inst[31:25];
    assign alt     = inst[30];
    assign w_f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101);
    assign shift   = (f3 == 3'b001) || (f3 == 3'b101);
    assign imm_i   = {{52{inst[31]}}, inst[31:20]};
    assign imm_s   = {{52{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_u   = {{32{inst[31]}}, inst[31:12], 12'b0};
    assign rs1_w_z = {32'b0, bus.rs1_data[31:0]};
    assign rs1_w_s = {{32{bus.rs1_data[31]}}, bus.rs1_data[31:0]};

    always_comb begin
        dec  = '0;
        bad  = 1'b0;
        word = 1'b0;
        case (inst[6:0])
            OPC_OP, OPC_OP32: begin
                word = (inst[6:0] == OPC_OP32);
                bad  = (f7 != 7'b0000000 && f7 != 7'b0100000) || (word && !w_f3_ok) ||
                       (alt && f3 != 3'b000 && f3 != 3'b101);
                dec.alu_function = {word, alt, f3};
                dec.operand_a    = bus.rs1_data;
                dec.operand_b    = bus.rs2_data;
                dec.is_word      = word;
                // 32-bit right shifts need the upper half fixed up before a 64-bit shifter
                if (word && f3 == 3'b101)
                    dec.operand_a = alt ? rs1_w_s : rs1_w_z;
            end
            OPC_IMM, OPC_IMM32: begin
                word = (inst[6:0] == OPC_IMM32);
                bad  = (word && !w_f3_ok) ||
                       (shift && !word && inst[31:26] != 6'b000000 && inst[31:26] != 6'b010000) ||
                       (f3 == 3'b001 && alt);
                dec.alu_function = {word, alt && f3 == 3'b101, f3};
                dec.operand_a    = bus.rs1_data;
                dec.operand_b    = imm_i;
                dec.is_word      = word;
                if (shift)
                    dec.operand_b = word ? {59'b0, inst[24:20]} : {58'b0, inst[25:20]};
                if (word && f3 == 3'b101)
                    dec.operand_a = alt ? rs1_w_s : rs1_w_z;
            end
            OPC_LUI: begin
                dec.operand_b = imm_u;
            end
            OPC_AUIPC: begin
                dec.operand_a = bus.pc;
                dec.operand_b = imm_u;
            end
            OPC_LOAD: begin
                dec.operand_a = bus.rs1_data;
                dec.operand_b = imm_i;
            end
            OPC_STORE: begin
                dec.operand_a = bus.rs1_data;
                dec.operand_b = imm_s;
            end
            OPC_BRANCH: begin
                bad = (f3[2:1] == 2'b01);
                dec.alu_function  = f3[2] ? {4'b0001, f3[1]} : 5'b01000;
                dec.operand_a     = bus.rs1_data;
                dec.operand_b     = bus.rs2_data;
                dec.is_branch     = 1'b1;
                dec.branch_invert = f3[0];
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    dec_t out_q;
    logic out_vld;

`ifdef ALU_ISSUE_SKID_EN
    dec_t skid_q;
    logic skid_vld;
    logic in_rdy_q;
    logic accept;

    // in_ready is a flop (skid empty); flush only forces it high
    assign bus.in_ready = in_rdy_q | flush;
    assign accept       = bus.in_valid && in_rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_q    <= '0;
            skid_vld <= 1'b0;
            skid_q   <= '0;
            in_rdy_q <= 1'b1;
        end else if (flush) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            in_rdy_q <= 1'b1;
        end else if (!out_vld || bus.out_ready) begin
            if (skid_vld) begin
                out_q    <= skid_q;
                out_vld  <= 1'b1;
                skid_vld <= 1'b0;
                in_rdy_q <= 1'b1;
            end else if (accept) begin
                out_q   <= dec;
                out_vld <= 1'b1;
            end else begin
                out_vld <= 1'b0;
            end
        end else if (accept) begin
            skid_q   <= dec;
            skid_vld <= 1'b1;
            in_rdy_q <= 1'b0;
        end
    end
`else
    logic accept;

    assign bus.in_ready = !out_vld || bus.out_ready || flush;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_q   <= '0;
        end else if (flush) begin
            out_vld <= 1'b0;
        end else if (accept) begin
            out_q   <= dec;
            out_vld <= 1'b1;
        end else if (bus.out_ready) begin
            out_vld <= 1'b0;
        end
    end
`endif

    assign bus.out_valid     = out_vld;
    assign bus.alu_function  = out_q.alu_function;
    assign bus.operand_a     = out_q.operand_a;
    assign bus.operand_b     = out_q.operand_b;
    assign bus.is_word       = out_q.is_word;
    assign bus.is_branch     = out_q.is_branch;
    assign bus.branch_invert = out_q.branch_invert;
    assign bus.illegal       = out_q.illegal;
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed vector table, flush/reset sequences, and a
// randomized stream scored against a behavioural RV64I decode model.
module tb_alu_issue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    alu_issue_if bus();
    alu_issue dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));

    typedef struct packed {
        logic [4:0]  fn;
        logic [63:0] a;
        logic [63:0] b;
        logic        w;
        logic        br;
        logic        inv;
        logic        ill;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [63:0] pc;
        logic [63:0] r1;
        logic [63:0] r2;
        exp_t        e;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t q[$];
    int   emitted = 0;
    bit   mon_en = 0;
    bit   stalled = 0;
    exp_t prev;
    logic [6:0] ops [0:8] = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63};

    function automatic exp_t got();
        exp_t g;
        g.fn = bus.alu_function; g.a = bus.operand_a; g.b = bus.operand_b;
        g.w = bus.is_word; g.br = bus.is_branch; g.inv = bus.branch_invert; g.ill = bus.illegal;
        return g;
    endfunction

    // Decode rules written straight from the RV64I field meanings
    function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc, input logic [63:0] r1,
                                   input logic [63:0] r2);
        exp_t        e = '0;
        bit          ok = 1;
        bit          wd;
        bit          sh;
        logic [2:0]  f3 = i[14:12];
        logic [6:0]  f7 = i[31:25];
        logic [63:0] lo_s = 64'($signed(r1[31:0]));
        logic [63:0] lo_z = 64'(r1[31:0]);
        logic [63:0] ii = 64'($signed(i[31:20]));
        case (i[6:0])
            7'h33, 7'h3B: begin
                wd = (i[6:0] == 7'h3B);
                ok = (f7 == 7'h00 || f7 == 7'h20) && (!wd || f3 inside {0, 1, 5}) &&
                     (f7 != 7'h20 || f3 inside {0, 5});
                e.fn = {wd, f7 == 7'h20, f3}; e.a = r1; e.b = r2; e.w = wd;
                if (wd && f3 == 5) e.a = (f7 == 7'h20) ? lo_s : lo_z;
            end
            7'h13, 7'h1B: begin
                wd = (i[6:0] == 7'h1B);
                sh = (f3 == 1 || f3 == 5);
                ok = (!wd || f3 inside {0, 1, 5}) && !(f3 == 1 && i[30]) &&
                     !(sh && !wd && !(i[31:26] inside {6'b000000, 6'b010000}));
                e.fn = {wd, f3 == 5 && i[30], f3}; e.a = r1; e.w = wd;
                e.b = !sh ? ii : (wd ? 64'(i[24:20]) : 64'(i[25:20]));
                if (wd && f3 == 5) e.a = i[30] ? lo_s : lo_z;
            end
            7'h37: e.b = 64'($signed({i[31:12], 12'b0}));
            7'h17: begin e.a = pc; e.b = 64'($signed({i[31:12], 12'b0})); end
            7'h03: begin e.a = r1; e.b = ii; end
            7'h23: begin e.a = r1; e.b = 64'($signed({i[31:25], i[11:7]})); end
            7'h63: begin
                ok = !(f3 inside {2, 3});
                e.a = r1; e.b = r2; e.br = 1; e.inv = f3[0];
                e.fn = (f3 < 4) ? 5'b01000 : ((f3 < 6) ? 5'b00010 : 5'b00011);
            end
            default: ok = 0;
        endcase
        if (!ok) begin e = '0; e.ill = 1; end
        return e;
    endfunction

    task automatic check_st(input string name, input logic vld_req, input exp_t req);
        exp_t act = got();
        n_vec++;
        if (bus.out_valid !== vld_req || act !== req) begin
            n_bad++;
            $display("FAIL %s: got vld=%b fn=%b a=%h b=%h w=%b br=%b inv=%b ill=%b, need vld=%b fn=%b a=%h b=%h w=%b br=%b inv=%b ill=%b",
                     name, bus.out_valid, act.fn, act.a, act.b, act.w, act.br, act.inv, act.ill,
                     vld_req, req.fn, req.a, req.b, req.w, req.br, req.inv, req.ill);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b, need %b", name, act, req);
        end
    endtask

    // Scoreboard sampled one time unit before each rising edge
    always begin
        @(negedge clk);
        #4;
        if (mon_en) begin
            if (stalled) check_st("hold", 1'b1, prev);
            if (bus.out_valid && bus.out_ready) begin
                emitted++;
                if (q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL stream: got unexpected output fn=%b, need none", bus.alu_function);
                end else begin
                    check_st("stream", 1'b1, q.pop_front());
                end
            end
            if (flush) q.delete();
            else if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.instruction, bus.pc, bus.rs1_data, bus.rs2_data));
            stalled = bus.out_valid && !bus.out_ready && !flush;
            prev = got();
        end else begin
            stalled = 0;
        end
    end

    function automatic logic [31:0] rand_ins();
        logic [31:0] i = $urandom;
        int          k = $urandom_range(0, 9);
        if (k == 9) return i;
        i[6:0] = ops[k];
        case ($urandom_range(0, 3))
            0: i[31:25] = 7'h00;
            1: i[31:25] = 7'h20;
            default: ;
        endcase
        return i;
    endfunction

    task automatic stream(input int n, input bit pat, input bit use_flush);
        int sent = 0;
        int cyc = 0;
        bit acc = 0;
        while (sent < n && cyc < 3000) begin
            @(posedge clk); #1;
            flush = use_flush && ($urandom_range(0, 19) == 0);
            if (!bus.in_valid || acc) begin
                bus.in_valid    = pat || ($urandom_range(0, 3) != 0);
                bus.instruction = rand_ins();
                bus.pc          = {$urandom, $urandom};
                bus.rs1_data    = {$urandom, $urandom};
                bus.rs2_data    = {$urandom, $urandom};
            end
            bus.out_ready = pat ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            @(negedge clk); #3;
            acc = bus.in_valid && bus.in_ready;
            if (acc) sent++;
            cyc++;
        end
        check1("stream_sent_in_budget", sent >= n, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 0; flush = 0; bus.out_ready = 1;
        repeat (10) @(posedge clk);
        #1;
        n_vec++;
        if (q.size() != 0 || bus.out_valid) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, out_valid=%b, need 0 pending", q.size(), bus.out_valid);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [31:0] ins, input logic [63:0] pc,
                                input logic [63:0] r1, input logic [63:0] r2, input logic [4:0] fn,
                                input logic [63:0] a, input logic [63:0] b, input logic w,
                                input logic br, input logic inv, input logic ill);
        vec_t v;
        v.name = nm; v.ins = ins; v.pc = pc; v.r1 = r1; v.r2 = r2;
        v.e = '{fn: fn, a: a, b: b, w: w, br: br, inv: inv, ill: ill};
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        bus.in_valid = 0; bus.out_ready = 0; bus.instruction = 0;
        bus.pc = 0; bus.rs1_data = 0; bus.rs2_data = 0;

        vecs.push_back(mk("subw", {7'h20, 5'd2, 5'd1, 3'b000, 5'd3, 7'h3B}, 0, 5, 7, 5'b11000, 5, 7, 1, 0, 0, 0));
        vecs.push_back(mk("sraiw", {7'h20, 5'd4, 5'd1, 3'b101, 5'd3, 7'h1B}, 0, 64'h8000_0000, 1, 5'b11101, 64'hFFFF_FFFF_8000_0000, 4, 1, 0, 0, 0));
        vecs.push_back(mk("bgeu", {7'h00, 5'd2, 5'd1, 3'b111, 5'd0, 7'h63}, 0, 3, 9, 5'b00011, 3, 9, 0, 1, 1, 0));
        vecs.push_back(mk("opc7f", 32'h0000_007F, 4, 11, 22, 5'b00000, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("slli_bad", {6'b000001, 6'd3, 5'd1, 3'b001, 5'd3, 7'h13}, 0, 11, 22, 5'b00000, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("add", {7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33}, 0, 10, 20, 5'b00000, 10, 20, 0, 0, 0, 0));
        vecs.push_back(mk("sra", {7'h20, 5'd2, 5'd1, 3'b101, 5'd3, 7'h33}, 0, 64'hFFFF_FFFF_FFFF_FFF0, 2, 5'b01101, 64'hFFFF_FFFF_FFFF_FFF0, 2, 0, 0, 0, 0));
        vecs.push_back(mk("slt_alt", {7'h20, 5'd2, 5'd1, 3'b010, 5'd3, 7'h33}, 0, 1, 2, 5'b00000, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("mul", {7'h01, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33}, 0, 1, 2, 5'b00000, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("addi_neg", {12'hFFF, 5'd1, 3'b000, 5'd3, 7'h13}, 0, 100, 0, 5'b00000, 100, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0));
        vecs.push_back(mk("srlw", {7'h00, 5'd2, 5'd1, 3'b101, 5'd3, 7'h3B}, 0, 64'hFFFF_FFFF_8000_0001, 5, 5'b10101, 64'h0000_0000_8000_0001, 5, 1, 0, 0, 0));
        vecs.push_back(mk("srli63", {6'b000000, 6'd63, 5'd1, 3'b101, 5'd3, 7'h13}, 0, 7, 0, 5'b00101, 7, 63, 0, 0, 0, 0));
        vecs.push_back(mk("srai63", {6'b010000, 6'd63, 5'd1, 3'b101, 5'd3, 7'h13}, 0, 7, 0, 5'b01101, 7, 63, 0, 0, 0, 0));
        vecs.push_back(mk("lui", {20'h80000, 5'd1, 7'h37}, 8, 9, 0, 5'b00000, 0, 64'hFFFF_FFFF_8000_0000, 0, 0, 0, 0));
        vecs.push_back(mk("auipc", {20'h00001, 5'd1, 7'h17}, 64'h1000, 9, 0, 5'b00000, 64'h1000, 64'h1000, 0, 0, 0, 0));
        vecs.push_back(mk("store", {7'h7F, 5'd2, 5'd1, 3'b011, 5'b11000, 7'h23}, 0, 64'h200, 5, 5'b00000, 64'h200, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0, 0));
        vecs.push_back(mk("load", {12'h010, 5'd1, 3'b011, 5'd3, 7'h03}, 0, 64'h300, 5, 5'b00000, 64'h300, 16, 0, 0, 0, 0));
        vecs.push_back(mk("bne", {7'h00, 5'd2, 5'd1, 3'b001, 5'd0, 7'h63}, 0, 1, 2, 5'b01000, 1, 2, 0, 1, 1, 0));
        vecs.push_back(mk("blt", {7'h00, 5'd2, 5'd1, 3'b100, 5'd0, 7'h63}, 0, 1, 2, 5'b00010, 1, 2, 0, 1, 0, 0));
        vecs.push_back(mk("br010", {7'h00, 5'd2, 5'd1, 3'b010, 5'd0, 7'h63}, 0, 1, 2, 5'b00000, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("sltw", {7'h00, 5'd2, 5'd1, 3'b010, 5'd3, 7'h3B}, 0, 1, 2, 5'b00000, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("slliw_alt", {7'h20, 5'd3, 5'd1, 3'b001, 5'd3, 7'h1B}, 0, 1, 2, 5'b00000, 0, 0, 0, 0, 0, 1));

        repeat (2) @(posedge clk);
        #1;
        check_st("reset_state", 1'b0, '0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        check1("in_ready_after_reset", bus.in_ready, 1'b1);

        foreach (vecs[k]) begin
            bus.instruction = vecs[k].ins; bus.pc = vecs[k].pc;
            bus.rs1_data = vecs[k].r1; bus.rs2_data = vecs[k].r2;
            bus.in_valid = 1; bus.out_ready = 1;
            @(posedge clk); #1;
            bus.in_valid = 0;
            check_st(vecs[k].name, 1'b1, vecs[k].e);
            @(posedge clk); #1;
        end

        // flush while stalled with a new instruction offered
        bus.instruction = vecs[5].ins; bus.in_valid = 1; bus.out_ready = 0;
        @(posedge clk); #1;
        bus.instruction = vecs[13].ins; flush = 1;
        #2 check1("flush_in_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        flush = 0; bus.in_valid = 0;
        check1("flush_clears", bus.out_valid, 1'b0);
        @(posedge clk); #1;
        check1("flush_no_capture", bus.out_valid, 1'b0);

        // reset while an entry is held
        bus.instruction = vecs[0].ins; bus.rs1_data = 5; bus.in_valid = 1;
        @(posedge clk); #1;
        bus.in_valid = 0;
        check1("held_before_reset", bus.out_valid, 1'b1);
        #2 rst_n = 0;
        #1 check_st("reset_async", 1'b0, '0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        check1("reset_discard_valid", bus.out_valid, 1'b0);
        check1("reset_in_ready", bus.in_ready, 1'b1);

        mon_en = 1;
        emitted = 0;
        stream(8, 1'b1, 1'b0);
        n_vec++;
        if (emitted != 8) begin
            n_bad++;
            $display("FAIL stream8_count: got %0d emitted, need 8", emitted);
        end
        stream(400, 1'b0, 1'b1);
        mon_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 flush  input  1  synchronous discard of all held entries.
REQ-004 in_valid / in_ready  input / output  1 / 1  upstream handshake; transfer when both high.
REQ-005 instruction  input  32  RV64I instruction word.
REQ-006 pc  input  64  instruction address.
REQ-007 rs1_data, rs2_data  input  64 each  register operands.
REQ-008 out_valid / out_ready  output / input  1 / 1  downstream (ALU stage) handshake.
REQ-009 alu_function  output  5  [4]=5-bit shamt/word op, [3]=SUB/SRA, [2:0]=group (000 ADD_SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SHIFTR, 110 OR, 111 AND).
REQ-010 operand_a, operand_b  output  64 each  ALU operands.
REQ-011 is_word  output  1  result to be sign-extended from bit 31 downstream.
REQ-012 is_branch, branch_invert  output  1 each  branch compare and taken-polarity inversion.
REQ-013 illegal  output  1  instruction not decodable by this block.

Function
REQ-014 Decode SHALL be registered: accepted instruction appears on outputs with out_valid the cycle after acceptance (latency 1).
REQ-015 Outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-016 OP / OP-32: alu_function[2:0]=funct3; [3]=inst[30] only for funct3 000/101; [4]=1 for OP-32; operands rs1, rs2.
REQ-017 OP-IMM / OP-IMM-32: operand_b=sign-extended inst[31:20]; for shifts operand_b=shamt (inst[25:20] / inst[24:20]); [3]=inst[30] only when funct3=101; ADDI never SUB.
REQ-018 SRLW/SRLIW: operand_a=zero-extended rs1[31:0]; SRAW/SRAIW: operand_a=sign-extended rs1[31:0]; other W ops pass rs1; is_word=1 for all OP-32/OP-IMM-32.
REQ-019 LUI: operand_a=0, operand_b=sign-extended {inst[31:12],12'b0}, ADD; AUIPC: operand_a=pc, same operand_b, ADD.
REQ-020 LOAD: rs1 + I-imm, ADD; STORE: rs1 + S-imm {inst[31:25],inst[11:7]}, ADD.
REQ-021 BRANCH: operands rs1, rs2, is_branch=1; BEQ/BNE -> SUB; BLT/BGE -> SLT; BLTU/BGEU -> SLTU; branch_invert=1 for BNE, BGE, BGEU.
REQ-022 illegal=1 for: unsupported opcode; funct7 not 0000000/0100000 on OP/OP-32; inst[31:26] not 000000/010000 on 64-bit immediate shifts; OP-32/OP-IMM-32 funct3 outside {000,001,101}; inst[30]=1 where no SUB/SRA variant exists; BRANCH funct3 010/011.
REQ-023 Illegal entries SHALL still flow through the handshake with alu_function=00000, operands 0, is_word/is_branch/branch_invert=0.
REQ-024 Simultaneous accept and drain SHALL sustain one instruction per cycle with no bubble.
REQ-025 flush SHALL clear out_valid (and any skid entry) next cycle; flush wins over simultaneous in_valid; in_ready high while flush asserted.

Reset
REQ-026 During rst_n=0: out_valid=0, alu_function=0, operands=0, is_word=0, is_branch=0, branch_invert=0, illegal=0, skid empty.
REQ-027 in_ready=1 from the first cycle after reset release; reset mid-transfer discards held entries without emitting them.

Configuration
REQ-028 Macro ALU_ISSUE_SKID_EN defined: 2-entry skid buffer; in_ready driven directly from a flop (=skid empty); no combinational path out_ready -> in_ready; full throughput kept.
REQ-029 ALU_ISSUE_SKID_EN undefined: single stage; in_ready = !out_valid | out_ready (combinational); identical decode and ordering.

Verification
REQ-030 SUBW x, rs1=0x0000_0000_0000_0005, rs2=7 -> alu_function=11000, operands 5/7, is_word=1, illegal=0.
REQ-031 SRAIW shamt=4, rs1=0x0000_0000_8000_0000 -> alu_function=11101, operand_a=0xFFFF_FFFF_8000_0000, operand_b=4.
REQ-032 BGEU rs1=3, rs2=9 -> alu_function=00011, is_branch=1, branch_invert=1.
REQ-033 Back-to-back 8 instructions, out_ready toggling 1,0,0,1,... -> all 8 emitted in order, none dropped or duplicated, outputs stable while stalled.
REQ-034 out_valid=1, out_ready=0, flush=1 with in_valid=1 -> next cycle out_valid=0; new instruction not captured.
REQ-035 Opcode 0x7F and SLLI with inst[31:26]=000001 -> illegal=1, alu_function=00000, operands 0; with ALU_ISSUE_SKID_EN, in_ready independent of out_ready same cycle.
